// File: rtl/axis_packet_gen_if.sv
// axis_packet_gen_if: command and packet stream signals; master is the generator side, slave the environment side
interface axis_packet_gen_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] axis_in_data;
  logic axis_in_valid;
  logic axis_in_ready;
  logic [DATA_WIDTH-1:0] axis_out_data;
  logic axis_out_valid;
  logic axis_out_last;
  logic axis_out_ready;
  modport master (
    input axis_in_data, axis_in_valid, axis_out_ready,
    output axis_in_ready, axis_out_data, axis_out_valid, axis_out_last
  );
  modport slave (
    output axis_in_data, axis_in_valid, axis_out_ready,
    input axis_in_ready, axis_out_data, axis_out_valid, axis_out_last
  );
endinterface

// File: rtl/axis_packet_gen.sv
// axis_packet_gen: expands a {base,length} command into an AXI-Stream packet of STEP-spaced words
module axis_packet_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH = 16,
  parameter int unsigned STEP = 1
) (
  input logic clk,
  input logic rst,
  axis_packet_gen_if.master axis
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d, len;
  logic valid_q, valid_d, last_q, last_d, in_ready_q, in_ready_d;
  logic take, adv, step, done;
  always_comb begin
    len = axis.axis_in_data[LEN_WIDTH-1:0];
    take = state_q == IDLE && axis.axis_in_valid && in_ready_q && len != '0;
    adv = state_q == SEND && axis.axis_out_ready;
    step = adv && !last_q;
    done = adv && last_q;
    state_d = take ? SEND : done ? IDLE : state_q;
    data_d = take ? DATA_WIDTH'(axis.axis_in_data[DATA_WIDTH-1:LEN_WIDTH])
           : step ? data_q + DATA_WIDTH'(STEP) : data_q;
    rem_d = take ? len - LEN_WIDTH'(1) : step ? rem_q - LEN_WIDTH'(1) : rem_q;
    valid_d = take || (valid_q && !done);
    last_d = take ? len == LEN_WIDTH'(1) : step ? rem_q == LEN_WIDTH'(1) : done ? 1'b0 : last_q;
    in_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= IDLE;
      data_q <= '0;
      rem_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      rem_q <= rem_d;
      valid_q <= valid_d;
      last_q <= last_d;
      in_ready_q <= in_ready_d;
    end
  assign axis.axis_in_ready = in_ready_q;
  assign axis.axis_out_data = data_q;
  assign axis.axis_out_valid = valid_q;
  assign axis.axis_out_last = last_q;
endmodule

// File: tb/tb_axis_packet_gen.sv
// tb_axis_packet_gen: random commands and sink back-pressure, scoreboard against a packet-level model
module tb_axis_packet_gen;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam logic [DW-1:0] STEP = 8'h1D;
  typedef struct packed {
    logic [DW-1:0] d;
    logic l;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  bit rand_rdy = 1'b0;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  axis_packet_gen_if #(.DATA_WIDTH(DW)) axis ();
  axis_packet_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .STEP(STEP)) dut (
    .clk(clk),
    .rst(rst),
    .axis(axis)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic send(input logic [DW-LW-1:0] b, input logic [LW-1:0] n);
    int w;
    @(posedge clk); #1;
    axis.axis_in_valid = 1'b1;
    axis.axis_in_data = {b, n};
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!axis.axis_in_ready && w < 200);
    chk("cmd_accept", axis.axis_in_ready, 1);
    for (int i = 0; i < int'(n); i++) q.push_back('{d: DW'(b) + DW'(i) * STEP, l: i == int'(n) - 1});
    @(posedge clk); #1;
    axis.axis_in_valid = 1'b0;
    axis.axis_in_data = DW'($urandom);
    @(negedge clk);
    if (n == 0) begin
      chk("n0_no_valid", axis.axis_out_valid, 0);
      chk("n0_ready", axis.axis_in_ready, 1);
    end else begin
      chk("latency_valid", axis.axis_out_valid, 1);
      chk("latency_data", axis.axis_out_data, DW'(b));
    end
  endtask
  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_empty", q.size(), 0);
  endtask
  always begin
    @(posedge clk); #1;
    axis.axis_out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end
  initial begin
    logic pstall, plast, pl;
    logic [DW-1:0] pd;
    exp_t e;
    pstall = 1'b0;
    plast = 1'b0;
    pl = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (plast) begin
        chk("bubble_in_ready", axis.axis_in_ready, 1);
        chk("bubble_valid", axis.axis_out_valid, 0);
      end
      if (pstall) begin
        chk("stall_valid", axis.axis_out_valid, 1);
        chk("stall_data", axis.axis_out_data, pd);
        chk("stall_last", axis.axis_out_last, pl);
      end
      chk("last_without_valid", axis.axis_out_last & ~axis.axis_out_valid, 0);
      if (axis.axis_out_valid) chk("in_ready_while_send", axis.axis_in_ready, 0);
      plast = 1'b0;
      if (axis.axis_out_valid && axis.axis_out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %0h expected none", axis.axis_out_data);
        end else begin
          e = q.pop_front();
          chk("word_data", axis.axis_out_data, e.d);
          chk("word_last", axis.axis_out_last, e.l);
          plast = axis.axis_out_last && rst;
        end
      end
      pstall = axis.axis_out_valid && !axis.axis_out_ready && rst;
      pd = axis.axis_out_data;
      pl = axis.axis_out_last;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    axis.axis_in_valid = 1'b0;
    axis.axis_in_data = '0;
    axis.axis_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", axis.axis_out_valid, 0);
    chk("rst_last", axis.axis_out_last, 0);
    chk("rst_data", axis.axis_out_data, 0);
    chk("rst_in_ready", axis.axis_in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready_before_edge", axis.axis_in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready", axis.axis_in_ready, 1);
    send(4'd5, 4'd3);
    drain();
    send(4'd7, 4'd0);
    send(4'd9, 4'd1);
    drain();
    send(4'hF, 4'hF);
    drain();
    rand_rdy = 1'b1;
    send(4'd2, 4'd4);
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(DW'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0) ? 4'd0 :
           ($urandom_range(0, 7) == 0) ? 4'hF : LW'($urandom_range(1, 15)));
    end
    drain();
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    send(4'd3, 4'd5);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", axis.axis_out_valid, 0);
    chk("abort_last", axis.axis_out_last, 0);
    chk("abort_data", axis.axis_out_data, 0);
    chk("abort_in_ready", axis.axis_in_ready, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_rel_in_ready", axis.axis_in_ready, 1);
    send(4'd1, 4'd2);
    drain();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
